// File: rtl/io_db_pkg.sv
// Shared defaults and board channel map for the IO debounce bank.
// Channel order matches the FPGA top-level raw input bus: SW[16:0], KEY[3:0], reset switch.
package io_db_pkg;

  localparam int DEF_NUM_CH      = 22;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 500000;
  localparam int DEF_CNT_W       = 20;
  localparam int DEF_HOLD_CYCLES = 2500000;

  localparam int CH_SW0  = 0,  CH_SW1  = 1,  CH_SW2  = 2,  CH_SW3  = 3;
  localparam int CH_SW4  = 4,  CH_SW5  = 5,  CH_SW6  = 6,  CH_SW7  = 7;
  localparam int CH_SW8  = 8,  CH_SW9  = 9,  CH_SW10 = 10, CH_SW11 = 11;
  localparam int CH_SW12 = 12, CH_SW13 = 13, CH_SW14 = 14, CH_SW15 = 15;
  localparam int CH_SW16 = 16;
  localparam int CH_KEY0 = 17, CH_KEY1 = 18, CH_KEY2 = 19, CH_KEY3 = 20;
  localparam int CH_RST  = 21;

  // KEY buttons are active low, so their idle level is 1.
  localparam logic [DEF_NUM_CH-1:0] KEY_IDLE_LVL = 22'h1E_0000;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_db_channel.sv
// One input-conditioning slice: synchroniser, stability-count debounce and
// registered rise/fall pulses that coincide with the first cycle of a new level.
module io_db_channel
  import io_db_pkg::*;
#(
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   DB_CYCLES   = DEF_DB_CYCLES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic INIT_LVL    = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CNT_W-1:0]       cnt;
  logic                   sync_q;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_r  <= {SYNC_STAGES{INIT_LVL}};
      level_o <= INIT_LVL;
      cnt     <= '0;
      rise_o  <= 1'b0;
      fall_o  <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], raw_i};
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      // Any agreeing sample restarts the stability window.
      if (sync_q == level_o) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_o <= sync_q;
        cnt     <= '0;
        rise_o  <= sync_q;
        fall_o  <= ~sync_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_debounce_bank.sv
// Debounced input bank feeding the core's IO inputs and IO status word.
// Define IO_DB_HOLD_RST_EN to add the long-press reset request on channel RST_CH.
module io_debounce_bank
  import io_db_pkg::*;
#(
  parameter int                NUM_CH      = DEF_NUM_CH,
  parameter int                SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int                DB_CYCLES   = DEF_DB_CYCLES,
  parameter int                CNT_W       = DEF_CNT_W,
  parameter logic [NUM_CH-1:0] INIT_LVL    = '0,
  parameter int                RST_CH      = CH_RST,
  parameter int                HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NUM_CH-1:0] raw_i,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] rise_o,
  output logic [NUM_CH-1:0] fall_o,
  output logic [NUM_CH-1:0] evt_o,
  input  logic [NUM_CH-1:0] evt_clr_i,
  output logic              rst_req_o
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("io_debounce_bank: SYNC_STAGES must be 2..4");
  end
  if (DB_CYCLES < 1 || CNT_W < cnt_width(DB_CYCLES - 1)) begin : g_bad_db
    $error("io_debounce_bank: DB_CYCLES must be >= 1 and fit in CNT_W");
  end
  if (RST_CH < 0 || RST_CH >= NUM_CH || HOLD_CYCLES < 1) begin : g_bad_hold
    $error("io_debounce_bank: RST_CH out of range or HOLD_CYCLES < 1");
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    io_db_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W),
      .INIT_LVL    (INIT_LVL[i])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .raw_i   (raw_i[i]),
      .level_o (level_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

  // A rise in the same cycle as a clear must not be lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      evt_o <= '0;
    end else begin
      evt_o <= rise_o | (evt_o & ~evt_clr_i);
    end
  end

`ifdef IO_DB_HOLD_RST_EN
  localparam int              HOLD_W   = cnt_width(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES);

  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  always_comb begin
    hold_nxt = '0;
    if (level_o[RST_CH]) begin
      hold_nxt = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
    end
  end

  // Request is registered from the next count so it rises with the count reaching HOLD_MAX.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt  <= '0;
      rst_req_o <= 1'b0;
    end else begin
      hold_cnt  <= hold_nxt;
      rst_req_o <= (hold_nxt == HOLD_MAX);
    end
  end
`else
  assign rst_req_o = 1'b0;
`endif

endmodule
